keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment display driver: scans a 4x4 matrix keypad by strobing active-low column enables, one column at a time.
- Reads the active-low row lines, debounces over whole scans, and reports one key code per press, plus held and release status.
- Sits beside the display driver in the top level.
- Shares the 12 MHz Clk.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_tick_gen.sv | 25 ++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, column
// strobe patterns, scan classification and key-code packing.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } scan_kind_e;

   typedef struct packed {
      scan_kind_e kind;
      logic [3:0] code;
   } scan_res_t;

   localparam logic [3:0] COL0 = 4'b1110;
   localparam logic [3:0] COL1 = 4'b1101;
   localparam logic [3:0] COL2 = 4'b1011;
   localparam logic [3:0] COL3 = 4'b0111;

   // Element i is the active-low strobe for column i.
   localparam logic [3:0][3:0] COL_SEL = {COL3, COL2, COL1, COL0};

   function automatic logic [3:0] col_enable(input logic [1:0] idx);
      return COL_SEL[idx];
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
      return {row_idx, col_idx};
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column-slot prescaler: counts 0..TICK_DIV-1 and flags the last count.
module keypad_tick_gen
   import keypad_pkg::*;
#(
   parameter int unsigned TICK_DIV = 12000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);
   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column per tick, classifies each full
// scan, and debounces presses and releases over whole scans.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 12000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] KeyCode,
   output logic       KeyValid,
   output logic       KeyHeld,
   output logic       KeyRelease
);
   logic            tick;
   logic [3:0]      row_m_q, row_s_q;
   logic [1:0]      col_idx_q;
   logic [3:0]      col_q;
   logic [2:0][3:0] hits_q;
   logic            scan_done;

   logic [3:0][3:0] hits_all;
   logic [4:0]      n_hits;
   logic [3:0]      hit_code;
   scan_res_t       scan_res;

   kp_state_e       state_q;
   logic [3:0]      cnt_q, cnt_inc, cand_q, code_q;
   logic            press_evt_q, rel_evt_q;
   logic            valid_q, held_q, release_q;

   keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_i (Clk),
      .rst_i (Rst),
      .tick_o(tick)
   );

   assign scan_done = tick && (col_idx_q == 2'd3);

   // Row is asynchronous; the column strobe and row sampling run off tick.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         row_m_q   <= 4'hF;
         row_s_q   <= 4'hF;
         col_idx_q <= 2'd0;
         col_q     <= COL0;
         hits_q    <= '0;
      end else begin
         row_m_q <= Row;
         row_s_q <= row_m_q;
         if (tick) begin
            case (col_idx_q)
               2'd0:    hits_q[0] <= ~row_s_q;
               2'd1:    hits_q[1] <= ~row_s_q;
               2'd2:    hits_q[2] <= ~row_s_q;
               default: ;
            endcase
            col_idx_q <= col_idx_q + 2'd1;
            col_q     <= col_enable(col_idx_q + 2'd1);
         end
      end
   end

   // Column 3 is taken straight from row_s so the result is ready on its tick.
   always_comb begin
      hits_all = {~row_s_q, hits_q[2], hits_q[1], hits_q[0]};
      n_hits   = '0;
      hit_code = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (hits_all[c][r]) begin
               n_hits   = n_hits + 5'd1;
               hit_code = key_code(2'(r), 2'(c));
            end
         end
      end
      scan_res.code = hit_code;
      if (n_hits == 5'd0)      scan_res.kind = NONE;
      else if (n_hits == 5'd1) scan_res.kind = SINGLE;
      else                     scan_res.kind = MULTI;
   end

   assign cnt_inc = cnt_q + 4'd1;

   // Events are flagged on the transition edge and surface one edge later.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= '0;
         code_q      <= '0;
         press_evt_q <= 1'b0;
         rel_evt_q   <= 1'b0;
         valid_q     <= 1'b0;
         held_q      <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         press_evt_q <= 1'b0;
         rel_evt_q   <= 1'b0;
         valid_q     <= press_evt_q;
         release_q   <= rel_evt_q;
         if (press_evt_q)    held_q <= 1'b1;
         else if (rel_evt_q) held_q <= 1'b0;

         if (scan_done) begin
            case (state_q)
               IDLE: begin
                  if (scan_res.kind == SINGLE) begin
                     cand_q  <= scan_res.code;
                     cnt_q   <= 4'd1;
                     state_q <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (scan_res.kind == SINGLE && scan_res.code == cand_q) begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
                        code_q      <= cand_q;
                        state_q     <= PRESSED;
                        press_evt_q <= 1'b1;
                     end
                  end else if (scan_res.kind == SINGLE) begin
                     cand_q <= scan_res.code;
                     cnt_q  <= 4'd1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               PRESSED: begin
                  if (scan_res.kind == NONE) begin
                     cnt_q   <= 4'd1;
                     state_q <= RELEASE;
                  end
               end
               RELEASE: begin
                  if (scan_res.kind == NONE) begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
                        state_q   <= IDLE;
                        rel_evt_q <= 1'b1;
                     end
                  end else begin
                     state_q <= PRESSED;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Col        = col_q;
   assign KeyCode    = code_q;
   assign KeyValid   = valid_q;
   assign KeyHeld    = held_q;
   assign KeyRelease = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: a scan-level reference model predicts
// press/release events, a monitor matches them against the DUT outputs.
module tb_keypad_scanner;
   localparam int TD   = 8;
   localparam int DS   = 4;
   localparam int SCAN = 4 * TD;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [3:0]  Row, Col, KeyCode;
   logic        KeyValid, KeyHeld, KeyRelease;
   logic [15:0] keys = '0;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE_SCANS(DS)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Row       (Row),
      .Col       (Col),
      .KeyCode   (KeyCode),
      .KeyValid  (KeyValid),
      .KeyHeld   (KeyHeld),
      .KeyRelease(KeyRelease)
   );

   // Key (r,c) pressed pulls row r low while column c is strobed.
   always_comb begin
      Row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !Col[c]) Row[r] = 1'b0;
   end

   typedef struct {
      bit         rel;
      logic [3:0] code;
      longint     cyc;
   } ev_t;

   ev_t         expq[$];
   longint      gcyc = 0;
   int          j = 0;
   bit          tracked = 1'b0;
   bit          last_rst = 1'b0;
   logic [15:0] k0 = '0, k1 = '0, k2 = '0, scan_hits = '0;
   int          run_len = 0, run_code = 0, none_run = 0;
   bit          m_held = 1'b0;
   logic [3:0]  m_code = '0;
   bit          held_next = 1'b0;
   longint      held_at = 0;
   int          mcol;

   // One full scan seen as a 16-bit key set; debounce is counted as run lengths.
   task automatic score_scan(input logic [15:0] h);
      int n;
      int code;
      ev_t e;
      n    = $countones(h);
      code = 0;
      for (int i = 0; i < 16; i++) if (h[i]) code = i;
      if (n == 1) begin
         if (run_len > 0 && run_code == code) run_len++;
         else begin
            run_len  = 1;
            run_code = code;
         end
      end else run_len = 0;
      if (n == 0) none_run++;
      else        none_run = 0;
      if (!m_held && n == 1 && run_len == DS) begin
         m_held = 1'b1;
         m_code = 4'(code);
         e.rel = 1'b0; e.code = m_code; e.cyc = gcyc + 1;
         expq.push_back(e);
         held_next = 1'b1; held_at = gcyc + 1;
      end else if (m_held && n == 0 && none_run == DS) begin
         m_held = 1'b0;
         e.rel = 1'b1; e.code = m_code; e.cyc = gcyc + 1;
         expq.push_back(e);
         held_next = 1'b0; held_at = gcyc + 1;
      end
   endtask

   // Reference model: the row seen at a column's tick is the key set from two
   // clocks earlier (two-flop synchronizer).
   always @(posedge Clk) begin
      gcyc++;
      k2 = k1; k1 = k0; k0 = keys;
      last_rst = Rst;
      if (Rst) begin
         tracked   = 1'b1;
         j         = 0;
         scan_hits = '0;
         run_len   = 0;
         none_run  = 0;
         m_held    = 1'b0;
         m_code    = '0;
         held_next = 1'b0;
         held_at   = gcyc;
         expq.delete();
      end else if (tracked) begin
         j++;
         if (j % TD == 0) begin
            mcol = (j / TD - 1) % 4;
            for (int r = 0; r < 4; r++)
               if (k2[r*4+mcol]) scan_hits[r*4+mcol] = 1'b1;
            if (mcol == 3) begin
               score_scan(scan_hits);
               scan_hits = '0;
            end
         end
      end
   end

   // Monitor: compares DUT outputs with the model on the falling edge.
   logic [3:0] exp_col;
   bit         exp_held = 1'b0;
   ev_t        got;
   always @(negedge Clk) begin
      if (tracked) begin
         exp_col = ~(4'b0001 << ((j / TD) % 4));
         checks++;
         if (Col !== exp_col) begin
            errors++;
            $display("FAIL col @%0d: got %b want %b", gcyc, Col, exp_col);
         end
         if (last_rst) begin
            checks++;
            if ({KeyCode, KeyValid, KeyHeld, KeyRelease} !== 7'd0) begin
               errors++;
               $display("FAIL reset_out @%0d: got code=%0d v=%b h=%b r=%b want all 0",
                        gcyc, KeyCode, KeyValid, KeyHeld, KeyRelease);
            end
         end
         while (expq.size() > 0 && expq[0].cyc < gcyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event @%0d: got no pulse want %s code=%0d at %0d",
                     gcyc, expq[0].rel ? "release" : "valid", expq[0].code, expq[0].cyc);
            void'(expq.pop_front());
         end
         if (KeyValid || KeyRelease) begin
            checks++;
            if (KeyValid && KeyRelease) begin
               errors++;
               $display("FAIL both_pulses @%0d: got valid=1 release=1 want at most one", gcyc);
            end else if (expq.size() == 0 || expq[0].cyc != gcyc) begin
               errors++;
               $display("FAIL unexpected_event @%0d: got valid=%b release=%b code=%0d want none",
                        gcyc, KeyValid, KeyRelease, KeyCode);
            end else begin
               got = expq.pop_front();
               if (KeyRelease !== got.rel || KeyCode !== got.code) begin
                  errors++;
                  $display("FAIL event @%0d: got release=%b code=%0d want release=%b code=%0d",
                           gcyc, KeyRelease, KeyCode, got.rel, got.code);
               end
            end
         end
         if (gcyc >= held_at) exp_held = held_next;
         checks++;
         if (KeyHeld !== exp_held) begin
            errors++;
            $display("FAIL held @%0d: got %b want %b", gcyc, KeyHeld, exp_held);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   int k_a, k_b, hold, gap;

   initial begin
      Rst = 1'b1;
      wait_cyc(3);
      Rst = 1'b0;
      wait_cyc(45);
      // reset in the middle of a scan
      Rst = 1'b1;
      wait_cyc(3);
      Rst = 1'b0;
      wait_cyc(40);

      // clean press and release of (1,2)
      keys = 16'h0040;
      wait_cyc(7 * SCAN);
      keys = '0;
      wait_cyc(7 * SCAN);

      // bounce on (3,3), then a steady hold
      for (int i = 0; i < 8; i++) begin
         keys[15] = ~keys[15];
         wait_cyc(20);
      end
      keys = 16'h8000;
      wait_cyc(7 * SCAN);
      keys = '0;
      wait_cyc(7 * SCAN);

      // two keys together, then one lifted
      keys = 16'h0201;
      wait_cyc(10 * SCAN);
      keys = 16'h0001;
      wait_cyc(7 * SCAN);
      keys = '0;
      wait_cyc(7 * SCAN);

      // release glitch on code 5, then rollover attempt with code 9
      keys = 16'h0020;
      wait_cyc(7 * SCAN);
      keys = '0;
      wait_cyc(2 * SCAN);
      keys = 16'h0020;
      wait_cyc(3 * SCAN);
      keys = 16'h0220;
      wait_cyc(3 * SCAN);
      keys = 16'h0020;
      wait_cyc(2 * SCAN);
      keys = '0;
      wait_cyc(7 * SCAN);

      // randomized presses, occasional second key and bounce
      for (int it = 0; it < 10; it++) begin
         k_a  = $urandom_range(0, 15);
         hold = $urandom_range(20, 260);
         gap  = $urandom_range(20, 260);
         keys = '0;
         keys[k_a] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            k_b = $urandom_range(0, 15);
            keys[k_b] = 1'b1;
         end
         if ($urandom_range(0, 2) == 0) begin
            for (int b = 0; b < 4; b++) begin
               wait_cyc($urandom_range(5, 40));
               keys[k_a] = ~keys[k_a];
            end
         end
         wait_cyc(hold);
         keys = '0;
         wait_cyc(gap);
      end

      wait_cyc(8 * SCAN);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d outstanding want 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
